// File: rtl/wload_ctrl_if.sv
// Weight-load controller bus bundle.
// Groups the core-controller handshake (start/base_addr/num_rows/busy/done/err), the weight
// SRAM read port, the input FIFO write/pop port and the array load port.
//   master : the wload_ctrl side (drives strobes, addresses and status)
//   slave  : the environment side (core controller, SRAM, FIFO, array)
interface wload_ctrl_if #(
    parameter int unsigned col = 8,
    parameter int unsigned bw  = 4,
    parameter int unsigned AW  = 11
);
    // Core controller handshake
    logic                start;
    logic [AW-1:0]       base_addr;
    logic [4:0]          num_rows;
    logic                busy;
    logic                done;
    logic                err;
    // Weight SRAM read port
    logic                sram_cen;
    logic [AW-1:0]       sram_addr;
    logic [col*bw-1:0]   sram_dout;
    // Input FIFO
    logic [col*bw-1:0]   fifo_in;
    logic                fifo_wr;
    logic                fifo_full;
    logic                fifo_rd;
    logic                fifo_empty;
    // Array load port
    logic                arr_ready;
    logic                arr_load;
    logic [3:0]          arr_row;

    modport master (
        input  start, base_addr, num_rows, sram_dout, fifo_full, fifo_empty, arr_ready,
        output busy, done, err, sram_cen, sram_addr, fifo_in, fifo_wr, fifo_rd, arr_load,
               arr_row
    );

    modport slave (
        output start, base_addr, num_rows, sram_dout, fifo_full, fifo_empty, arr_ready,
        input  busy, done, err, sram_cen, sram_addr, fifo_in, fifo_wr, fifo_rd, arr_load,
               arr_row
    );
endinterface

// File: rtl/wload_ctrl.sv
// Weight-load pass sequencer.
// Fetches N weight rows from the weight SRAM into the input FIFO, then drains the FIFO into
// the 2D array one row per accepted cycle, and reports busy/done/err to the core controller.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high; aborts any pass immediately
//   bus   : wload_ctrl_if master modport (controller handshake, SRAM, FIFO, array)
module wload_ctrl #(
    parameter int unsigned col        = 8,
    parameter int unsigned bw         = 4,
    parameter int unsigned AW         = 11,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    wload_ctrl_if.master bus
);

    localparam logic [4:0] MaxRows = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFlush,
        StDrain,
        StDone
    } state_e;

    state_e        state_q;
    logic [4:0]    n_q;        // effective row count for this pass
    logic [4:0]    rd_cnt_q;   // reads issued so far, minus the one in flight
    logic [4:0]    pop_cnt_q;  // rows handed to the array so far
    logic [AW-1:0] addr_q;
    logic          cen_q;
    logic          wr_q;       // pipeline flop: a read in cycle t becomes a write in t+1
    logic          err_q;
    logic          pop;

    // Pops are combinational so a row moves on the same cycle the array is ready.
    assign pop = (state_q == StDrain) & bus.arr_ready & ~bus.fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            n_q       <= '0;
            rd_cnt_q  <= '0;
            pop_cnt_q <= '0;
            addr_q    <= '0;
            cen_q     <= 1'b1;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_q <= ~cen_q;
            // The write is still strobed; the overflow is only flagged.
            if (wr_q && bus.fifo_full) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (!bus.fifo_empty) begin
                            // Leftover rows would be loaded into the array; refuse the pass.
                            err_q <= 1'b1;
                        end else begin
                            addr_q    <= bus.base_addr;
                            rd_cnt_q  <= '0;
                            pop_cnt_q <= '0;
                            if (bus.num_rows > MaxRows) begin
                                err_q <= 1'b1;
                                n_q   <= MaxRows;
                            end else begin
                                n_q   <= bus.num_rows;
                            end
                            if (bus.num_rows == 5'd0) begin
                                // Empty pass still spends one cycle before DONE so that done
                                // lands at the same 2N+2 offset as a real pass.
                                state_q <= StFlush;
                            end else begin
                                state_q <= StFetch;
                                cen_q   <= 1'b0;
                            end
                        end
                    end
                end
                StFetch: begin
                    if (rd_cnt_q == 5'(n_q - 5'd1)) begin
                        cen_q   <= 1'b1;
                        state_q <= StFlush;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 5'd1;
                        addr_q   <= addr_q + AW'(1);
                    end
                end
                StFlush: begin
                    state_q <= (n_q == 5'd0) ? StDone : StDrain;
                end
                StDrain: begin
                    if (pop) begin
                        pop_cnt_q <= pop_cnt_q + 5'd1;
                        if (pop_cnt_q == 5'(n_q - 5'd1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.err       = err_q;
    assign bus.sram_cen  = cen_q;
    assign bus.sram_addr = addr_q;
    // SRAM data is valid the cycle after the read, exactly when the write strobe is up.
    assign bus.fifo_in   = wr_q ? bus.sram_dout : '0;
    assign bus.fifo_wr   = wr_q;
    assign bus.fifo_rd   = pop;
    assign bus.arr_load  = pop;
    assign bus.arr_row   = pop_cnt_q[3:0];

endmodule

// File: tb/tb_wload_ctrl.sv
// Self-checking bench for wload_ctrl: SRAM and FIFO behavioural models plus directed passes.
module tb_wload_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wload_ctrl_if #(.col(8), .bw(4), .AW(11)) bus ();

    wload_ctrl #(
        .col(8),
        .bw(4),
        .AW(11),
        .FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fq[$];
    int   fcount   = 0;
    logic force_ne = 1'b0;
    int   cnt_rd   = 0;
    int   cnt_wr   = 0;
    int   cnt_pop  = 0;

    assign bus.fifo_empty = (fcount == 0) && !force_ne;
    assign bus.fifo_full  = (fcount >= 16);

    function automatic logic [31:0] rowdata(input logic [10:0] a);
        return {a[3:0], 8'hA5, 9'h0, a};
    endfunction

    // SRAM with one-cycle read latency, and a 16-entry FIFO reset with the DUT.
    always @(posedge clk) begin
        if (!bus.sram_cen) bus.sram_dout <= rowdata(bus.sram_addr);
        if (reset) begin
            fq.delete();
            fcount <= 0;
        end else begin
            if (bus.fifo_rd) begin
                cnt_pop++;
                if (fq.size() > 0) void'(fq.pop_front());
            end
            if (bus.fifo_wr) begin
                cnt_wr++;
                if (fq.size() < 16) fq.push_back(bus.fifo_in);
            end
            if (!bus.sram_cen) cnt_rd++;
            fcount <= fq.size();
        end
    end

    task automatic do_reset();
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_rows  = '0;
        bus.arr_ready = 1'b1;
        force_ne      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.sram_cen, bus.fifo_wr, bus.fifo_rd, bus.arr_load}
            !== 7'b0001000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0001000", {bus.busy, bus.done, bus.err,
                     bus.sram_cen, bus.fifo_wr, bus.fifo_rd, bus.arr_load});
        end
        n_checks++;
        if (bus.sram_addr !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_addr: got %h expected 000", bus.sram_addr);
        end
        n_checks++;
        if (bus.fifo_in !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fifo_in: got %h expected 0", bus.fifo_in);
        end
        n_checks++;
        if (bus.arr_row !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_arr_row: got %0d expected 0", bus.arr_row);
        end
    endtask

    // Full pass with arr_ready held high; optionally pokes start in FETCH, DRAIN and DONE.
    task automatic test_pass(input logic [10:0] base, input logic [4:0] nreq, input bit poke,
                             input bit exp_err);
        int n;
        int r0;
        int w0;
        int p0;
        logic e_cen;
        logic e_wr;
        logic e_load;
        logic e_done;
        logic e_busy;
        logic [10:0] a;
        n = (nreq > 16) ? 16 : int'(nreq);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_rows  = nreq;
        bus.arr_ready = 1'b1;
        r0 = cnt_rd;
        w0 = cnt_wr;
        p0 = cnt_pop;
        for (int c = 1; c <= 2 * n + 3; c++) begin
            @(negedge clk);
            bus.start     = poke && (c == 2 || c == n + 3 || c == 2 * n + 2);
            bus.base_addr = 11'h300;
            bus.num_rows  = 5'd5;
            #1;
            e_cen  = !(c >= 1 && c <= n);
            e_wr   = (c >= 2 && c <= n + 1);
            e_load = (c >= n + 2 && c <= 2 * n + 1);
            e_done = (c == 2 * n + 2);
            e_busy = (c >= 1 && c <= 2 * n + 2);
            n_checks++;
            if ({bus.sram_cen, bus.fifo_wr, bus.arr_load, bus.fifo_rd, bus.done, bus.busy,
                 bus.err} !== {e_cen, e_wr, e_load, e_load, e_done, e_busy, exp_err}) begin
                n_fail++;
                $display("FAIL pass_ctrl n=%0d cycle %0d: cen/wr/load/rd/done/busy/err got %b expected %b",
                         n, c, {bus.sram_cen, bus.fifo_wr, bus.arr_load, bus.fifo_rd, bus.done,
                         bus.busy, bus.err}, {e_cen, e_wr, e_load, e_load, e_done, e_busy, exp_err});
            end
            if (!e_cen) begin
                a = base + 11'(c - 1);
                n_checks++;
                if (bus.sram_addr !== a) begin
                    n_fail++;
                    $display("FAIL pass_addr cycle %0d: got %h expected %h", c, bus.sram_addr, a);
                end
            end
            if (e_wr) begin
                a = base + 11'(c - 2);
                n_checks++;
                if (bus.fifo_in !== rowdata(a)) begin
                    n_fail++;
                    $display("FAIL pass_fifo_in cycle %0d: got %h expected %h", c, bus.fifo_in,
                             rowdata(a));
                end
            end
            if (e_load) begin
                a = base + 11'(c - n - 2);
                n_checks++;
                if (bus.arr_row !== 4'(c - n - 2)) begin
                    n_fail++;
                    $display("FAIL pass_arr_row cycle %0d: got %0d expected %0d", c, bus.arr_row,
                             c - n - 2);
                end
                n_checks++;
                if (fq.size() == 0 || fq[0] !== rowdata(a)) begin
                    n_fail++;
                    $display("FAIL pass_head cycle %0d: got %h expected %h", c,
                             (fq.size() == 0) ? 32'hx : fq[0], rowdata(a));
                end
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if ({cnt_rd - r0, cnt_wr - w0, cnt_pop - p0, fcount} !== {n, n, n, 0}) begin
            n_fail++;
            $display("FAIL pass_counts n=%0d: reads %0d writes %0d pops %0d fifo %0d expected %0d %0d %0d 0",
                     n, cnt_rd - r0, cnt_wr - w0, cnt_pop - p0, fcount, n, n, n);
        end
    endtask

    // N=3 with arr_ready 1,0,0,1,1 over cycles 5..9: pops in cycles 5, 8, 9; done in 10.
    task automatic test_stall();
        logic [4:0]  pat;
        logic        e_load;
        logic [3:0]  e_row;
        logic [10:0] a;
        pat = 5'b11001;  // bit 0 is cycle 5
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 11'h040;
        bus.num_rows  = 5'd3;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.arr_ready = (c >= 5 && c <= 9) ? pat[c-5] : 1'b1;
            #1;
            e_load = (c == 5 || c == 8 || c == 9);
            e_row  = (c == 5) ? 4'd0 : (c == 8) ? 4'd1 : 4'd2;
            n_checks++;
            if ({bus.arr_load, bus.fifo_rd, bus.done, bus.busy} !==
                {e_load, e_load, c == 10, c >= 1 && c <= 10}) begin
                n_fail++;
                $display("FAIL stall_ctrl cycle %0d: load/rd/done/busy got %b expected %b", c,
                         {bus.arr_load, bus.fifo_rd, bus.done, bus.busy},
                         {e_load, e_load, c == 10, c >= 1 && c <= 10});
            end
            if (e_load) begin
                a = 11'h040 + 11'(e_row);
                n_checks++;
                if (bus.arr_row !== e_row || fq.size() == 0 || fq[0] !== rowdata(a)) begin
                    n_fail++;
                    $display("FAIL stall_row cycle %0d: row %0d expected %0d", c, bus.arr_row,
                             e_row);
                end
            end
        end
        bus.arr_ready = 1'b1;
    endtask

    task automatic test_nonempty();
        do_reset();
        force_ne = 1'b1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.num_rows = 5'd4;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            n_checks++;
            if ({bus.busy, bus.err, bus.sram_cen, bus.fifo_wr, bus.fifo_rd} !== 5'b01100) begin
                n_fail++;
                $display("FAIL nonempty cycle %0d: busy/err/cen/wr/rd got %b expected 01100", c,
                         {bus.busy, bus.err, bus.sram_cen, bus.fifo_wr, bus.fifo_rd});
            end
        end
        force_ne = 1'b0;
    endtask

    // N=8: pops in cycles 10, 11; reset in cycle 12 with the array stalled.
    task automatic test_reset_mid();
        int p0;
        do_reset();
        p0 = cnt_pop;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 11'h100;
        bus.num_rows  = 5'd8;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(negedge clk);
        bus.arr_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.sram_cen, bus.fifo_wr, bus.fifo_rd, bus.arr_load}
            !== 7'b0001000 || bus.sram_addr !== 11'h0 || bus.arr_row !== 4'd0 ||
            bus.fifo_in !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: flags %b addr %h row %0d in %h expected 0001000 0 0 0",
                     {bus.busy, bus.done, bus.err, bus.sram_cen, bus.fifo_wr, bus.fifo_rd,
                     bus.arr_load}, bus.sram_addr, bus.arr_row, bus.fifo_in);
        end
        n_checks++;
        if (cnt_pop - p0 !== 2 || fcount !== 0) begin
            n_fail++;
            $display("FAIL midreset_pops: pops %0d fifo %0d expected 2 0", cnt_pop - p0, fcount);
        end
        @(negedge clk);
        reset         = 1'b0;
        bus.arr_ready = 1'b1;
        test_pass(11'h020, 5'd2, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_pass(11'h010, 5'd4, 1'b0, 1'b0);
        test_pass(11'h7FE, 5'd16, 1'b0, 1'b0);
        test_stall();
        do_reset();
        test_pass(11'h000, 5'd20, 1'b0, 1'b1);
        do_reset();
        test_pass(11'h123, 5'd0, 1'b0, 1'b0);
        test_nonempty();
        do_reset();
        test_pass(11'h010, 5'd4, 1'b1, 1'b0);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
